// File: rtl/oscillator.sv
// -----------------------------------------------------------------------------
// oscillator
//   Per-voice waveform generator feeding the envelope stage. Each sample_tick
//   advances a phase accumulator and a 32-bit Galois LFSR. A two-stage
//   pipeline turns the captured phase/noise state into one signed sample
//   (saw, square, triangle or noise). The voice gate is delayed by the same
//   two cycles so that gate and sample stay aligned downstream.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   sample_tick  one-cycle strobe, advances the oscillator by one sample
//   phase_inc    frequency word, sampled on tick
//   wave_sel     0=saw 1=square 2=triangle 3=noise, sampled on tick
//   pulse_width  square duty threshold, sampled on tick
//   note_on      phase-sync pulse, honoured only together with a tick
//   play_in      voice gate from the voice allocator
//   data_out     signed sample, held between valids
//   valid_out    one-cycle pulse when data_out updates
//   play_out     play_in delayed by exactly two clk cycles
// -----------------------------------------------------------------------------
module oscillator #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned PW_WIDTH    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_tick,
  input  logic [PHASE_WIDTH-1:0] phase_inc,
  input  logic [1:0]             wave_sel,
  input  logic [PW_WIDTH-1:0]    pulse_width,
  input  logic                   note_on,
  input  logic                   play_in,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   valid_out,
  output logic                   play_out
);

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_t;

  localparam logic [31:0]           LFSR_SEED = 32'hACE1ACE1;
  localparam logic [31:0]           LFSR_TAPS = 32'h80200003;
  localparam logic [DATA_WIDTH-1:0] SIGN_BIT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] S_MIN     = SIGN_BIT;
  localparam logic [DATA_WIDTH-1:0] S_MAX     = ~SIGN_BIT;

  // Accumulator state
  logic [PHASE_WIDTH-1:0] r_phase;
  logic [31:0]            r_lfsr;

  // Stage 1 registers
  logic                   r_s1_valid;
  logic [PHASE_WIDTH-1:0] r_s1_phase;
  wave_t                  r_s1_wave;
  logic [PW_WIDTH-1:0]    r_s1_pw;
  logic [31:0]            r_s1_lfsr;

  // Stage 2 / output registers
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_valid;
  logic                   r_play_d1;
  logic                   r_play_d2;

  // Combinational helpers
  logic [PHASE_WIDTH-1:0] w_p_used;
  logic [31:0]            w_lfsr_next;
  logic [PHASE_WIDTH-1:0] w_phase_shl;
  logic [DATA_WIDTH-1:0]  w_tri_t;
  logic [DATA_WIDTH-1:0]  w_tri_u;
  logic [DATA_WIDTH-1:0]  w_sample;

  // note_on forces the phase used for this sample to zero; the increment is
  // applied on top, so the following sample sits at phase_inc.
  assign w_p_used    = note_on ? '0 : r_phase;
  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

  // Triangle: doubled phase folded on the phase MSB.
  assign w_phase_shl = r_s1_phase << 1;
  assign w_tri_t     = w_phase_shl[PHASE_WIDTH-1 -: DATA_WIDTH];
  assign w_tri_u     = r_s1_phase[PHASE_WIDTH-1] ? ~w_tri_t : w_tri_t;

  always_comb begin
    w_sample = '0;
    unique case (r_s1_wave)
      WAVE_SAW:    w_sample = r_s1_phase[PHASE_WIDTH-1 -: DATA_WIDTH] ^ SIGN_BIT;
      WAVE_SQUARE: w_sample = (r_s1_phase[PHASE_WIDTH-1 -: PW_WIDTH] < r_s1_pw) ? S_MAX : S_MIN;
      WAVE_TRI:    w_sample = w_tri_u ^ SIGN_BIT;
      WAVE_NOISE:  w_sample = r_s1_lfsr[31 -: DATA_WIDTH];
      default:     w_sample = '0;
    endcase
  end

  // Accumulator and LFSR advance on every tick, regardless of wave_sel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase <= '0;
      r_lfsr  <= LFSR_SEED;
    end else if (sample_tick) begin
      r_phase <= w_p_used + phase_inc;
      r_lfsr  <= w_lfsr_next;
    end
  end

  // Stage 1: capture the pre-advance state alongside the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_phase <= '0;
      r_s1_wave  <= WAVE_SAW;
      r_s1_pw    <= '0;
      r_s1_lfsr  <= '0;
    end else begin
      r_s1_valid <= sample_tick;
      if (sample_tick) begin
        r_s1_phase <= w_p_used;
        r_s1_wave  <= wave_t'(wave_sel);
        r_s1_pw    <= pulse_width;
        r_s1_lfsr  <= r_lfsr;
      end
    end
  end

  // Stage 2: register the sample; data holds between valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data <= w_sample;
      end
    end
  end

  // Gate delay matches the two-stage sample pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_play_d1 <= 1'b0;
      r_play_d2 <= 1'b0;
    end else begin
      r_play_d1 <= play_in;
      r_play_d2 <= r_play_d1;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign play_out  = r_play_d2;

endmodule

// File: doc/oscillator.md
Name: oscillator

Overview:
Per-voice waveform generator directly upstream of the envelope stage. On each sample_tick it advances a phase accumulator and produces one signed sample (saw, square, triangle or LFSR noise) on data_out. It delays the voice gate (play_in) by the same pipeline depth, so the envelope sees play and data aligned. One instance per voice; the envelope consumes data_out and play_out directly.

Parameters:
DATA_WIDTH, 32, sample width (two's complement); legal range 8..32.
PHASE_WIDTH, 32, phase accumulator width; must be >= DATA_WIDTH.
PW_WIDTH, 8, pulse-width compare width; must be <= PHASE_WIDTH.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset; asserted when 0.
sample_tick  in  1  one-cycle strobe; advances the oscillator by one sample.
phase_inc  in  PHASE_WIDTH  frequency word; sampled on tick.
wave_sel  in  2  0=saw, 1=square, 2=triangle, 3=noise; sampled on tick.
pulse_width  in  PW_WIDTH  square duty threshold; sampled on tick.
note_on  in  1  phase-sync pulse; honoured only in a tick cycle.
play_in  in  1  voice gate from the voice allocator.
data_out  out  DATA_WIDTH  signed sample; held between valids.
valid_out  out  1  one-cycle pulse when data_out updates.
play_out  out  1  play_in delayed exactly 2 clk cycles.

Behaviour:
- Reset (rst=0, async) clears phase, all pipeline registers, data_out, valid_out and play_out to 0, and loads lfsr with 0xACE1ACE1. Deassertion is synchronised externally.
- Phase update: on a tick edge, p_used = note_on ? 0 : phase; phase <= p_used + phase_inc (mod 2^PHASE_WIDTH). With no tick, phase holds and note_on is ignored.
- LFSR: 32-bit Galois, right shift. If lfsr[0]=1, next = (lfsr>>1) ^ 0x80200003; otherwise next = lfsr>>1.
  - Advances on every tick, regardless of wave_sel.
  - The sample uses the pre-advance value.
  - note_on does not reset it.
- Stage 1 (tick edge): register p_used, wave_sel, pulse_width and the current lfsr, and set s1_valid=1. With no tick, s1_valid=0.
- Stage 2 (next edge, when s1_valid=1): compute the sample, register it to data_out and pulse valid_out=1. Otherwise valid_out=0 and data_out holds.
- Latency: a tick at edge N gives valid_out high for the cycle after edge N+1. Back-to-back ticks give back-to-back valids.
- Waveforms. P = PHASE_WIDTH, D = DATA_WIDTH, MSB conv = XOR with 2^(D-1) (offset-binary to two's complement).
  - saw = MSB conv of p[P-1 -: D]; p=0 gives the minimum.
  - square = MAX (2^(D-1)-1) if p[P-1 -: PW_WIDTH] < pulse_width, else MIN (-2^(D-1)). pulse_width=0 gives constant MIN.
  - triangle: t = top D bits of (p<<1); u = p[P-1] ? ~t : t; tri = MSB conv of u.
  - noise = lfsr[31 -: D].
- play_out is a plain 2-flop delay of play_in, independent of ticks.
- sample_tick must be low at least one cycle between ticks only if the upstream strobe generator requires it. The block itself accepts a tick every cycle.
- Reset mid-operation: outputs clear immediately, no valid is emitted for an in-flight sample, and the next tick after release restarts from phase 0.

Test Plan:
- Saw after reset: D=P=32, inc=0x40000000, wave_sel=0, 5 ticks -> data_out 0x80000000, 0xC0000000, 0x00000000, 0x40000000, 0x80000000; each valid_out comes 2 cycles after its tick.
- Square: inc=0x40000000, pw=0x80 -> MAX, MAX, MIN, MIN repeating. pw=0x00 -> always 0x80000000.
- Triangle: inc=0x40000000 -> 0x80000000, 0x00000000, 0x7FFFFFFF, 0xFFFFFFFF, then repeats.
- note_on asserted with a tick mid-run (phase=0xC0000000, saw) -> that sample is 0x80000000, the next is p=inc. note_on without a tick -> no effect.
- Noise: first tick after reset -> 0xACE1ACE1, second -> 0xD650D673. No ticks for 10 cycles -> valid_out stays 0 and data_out holds.
- Async reset mid-pipeline, plus play_in toggling -> outputs are 0 within the reset cycle with no stray valid. play_out follows play_in exactly 2 cycles later across 0->1->0.
